qspi_flash_responder: RTL and testbench

//  Synthesizable SPI-flash target: the responder end of the spi controller's serial link (CS, CLOCK, IO0..IO3).

---
 rtl/qspi_pkg.sv | 27 ++
 rtl/qspi_flash_responder_if.sv | 14 +
 rtl/spi_edge_sync.sv | 43 ++++
 rtl/qspi_flash_responder.sv | 198 +++++++++++++++++++
 tb/tb_qspi_flash_responder.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/qspi_pkg.sv
// Shared opcodes and state encoding for the SPI-flash responder.
// Pure declarations, no logic.
package qspi_pkg;

  localparam logic [7:0] OP_PP    = 8'h02;
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRDI  = 8'h04;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_QREAD = 8'h6B;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    RD_OUT,
    WR_IN,
    STAT_OUT,
    IGNORE
  } qspi_state_t;

  function automatic logic [7:0] status_byte(input logic wel);
    return {6'b0, wel, 1'b0};
  endfunction

endpackage

// File: rtl/qspi_flash_responder_if.sv
// Serial flash link between a SPI controller (master) and the flash responder (slave).
// Latency: none, wires only; backpressure: none, SCK is paced by the controller.
interface qspi_flash_responder_if;

  logic       spi_clk;
  logic       spi_cs_n;
  logic [3:0] io_i;
  logic [3:0] io_o;
  logic [3:0] io_oe;

  modport master (output spi_clk, spi_cs_n, io_i, input io_o, io_oe);
  modport slave  (input spi_clk, spi_cs_n, io_i, output io_o, io_oe);

endinterface

// File: rtl/spi_edge_sync.sv
// Two-flop synchronizers for SCK, CS# and IO pins, plus single-cycle edge pulses.
// Latency: pulses appear 2 clk after the pin edge is sampled; backpressure: none.
module spi_edge_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic       sck,
  input  logic       cs_n,
  input  logic [3:0] io,
  output logic       sck_rise,
  output logic       sck_fall,
  output logic       cs_rise,
  output logic       cs_fall,
  output logic [3:0] io_s
);

  logic [2:0] sck_q;
  logic [2:0] cs_q;
  logic [3:0] io_q0;
  logic [3:0] io_q1;

  // CS history resets low so a reset taken with CS# held low never produces
  // a CS fall: the responder stays idle until the controller reselects it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_q <= '0;
      cs_q  <= '0;
      io_q0 <= '0;
      io_q1 <= '0;
    end else begin
      sck_q <= {sck_q[1:0], sck};
      cs_q  <= {cs_q[1:0], cs_n};
      io_q0 <= io;
      io_q1 <= io_q0;
    end
  end

  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign cs_rise  = cs_q[1] & ~cs_q[2];
  assign cs_fall  = ~cs_q[1] & cs_q[2];
  assign io_s     = io_q1;

endmodule

// File: rtl/qspi_flash_responder.sv
// SPI-flash target serving READ/PP/WREN/WRDI/RDSR from a byte RAM; QSPI_QUAD_READ_EN adds quad read 0x6B.
// Latency: outputs change 3 clk after an SCK fall is sampled; backpressure: none, SCK <= clk/8 required.
module qspi_flash_responder
  import qspi_pkg::*;
#(
  parameter int ADDR_SIZE = 24,
  parameter int MEM_BYTES = 4096,
  parameter int DUMMY_CYC = 8
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  qspi_flash_responder_if.slave spi,
  output logic                  busy,
  output logic [7:0]            last_cmd
);

  localparam int AW = $clog2(MEM_BYTES);
  localparam int CW = $clog2(ADDR_SIZE + DUMMY_CYC + 1);

  logic          sck_rise, sck_fall, cs_rise, cs_fall;
  logic [3:0]    io_s;
  qspi_state_t   state, state_nxt;
  logic [CW-1:0] bit_cnt;
  logic [7:0]    sh;
  logic [7:0]    out_sh;
  logic [AW-1:0] addr;
  logic          wel;
  logic [7:0]    mem [MEM_BYTES];
  logic [7:0]    mem_q;
  logic [7:0]    opcode_in;
  logic [7:0]    mem_wd;
  logic          mem_we;
  logic [7:0]    ld_byte;
  logic [CW-1:0] out_bits;
  logic          quad_mode;
  logic [3:0]    io_o_r, io_oe_r;
  logic          io_unused;

  spi_edge_sync u_sync (
    .clk      (ACLK),
    .rst      (ARESET),
    .sck      (spi.spi_clk),
    .cs_n     (spi.spi_cs_n),
    .io       (spi.io_i),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .cs_rise  (cs_rise),
    .cs_fall  (cs_fall),
    .io_s     (io_s)
  );

  // Only IO0 carries controller data into this responder.
  assign io_unused = &{1'b0, io_s[3:1]};

`ifdef QSPI_QUAD_READ_EN
  assign quad_mode = (last_cmd == OP_QREAD);
`else
  assign quad_mode = 1'b0;
`endif

  assign busy      = (state != IDLE);
  assign spi.io_o  = io_o_r;
  assign spi.io_oe = io_oe_r;

  always_ff @(posedge ACLK) begin
    if (ARESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    opcode_in = {sh[6:0], io_s[0]};
    mem_wd    = opcode_in;
    mem_we    = 1'b0;
    ld_byte   = (state == STAT_OUT) ? status_byte(wel) : mem_q;
    out_bits  = quad_mode ? CW'(2) : CW'(8);
    if (cs_rise) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (cs_fall) state_nxt = CMD;
        CMD: begin
          if (sck_rise && bit_cnt == CW'(7)) begin
            case (opcode_in)
              OP_READ, OP_PP: state_nxt = ADDR;
`ifdef QSPI_QUAD_READ_EN
              OP_QREAD:       state_nxt = ADDR;
`endif
              OP_RDSR:        state_nxt = STAT_OUT;
              default:        state_nxt = IGNORE;
            endcase
          end
        end
        ADDR: begin
          if (sck_rise && bit_cnt == CW'(ADDR_SIZE - 1)) begin
            if (last_cmd == OP_PP) state_nxt = WR_IN;
            else if (quad_mode)    state_nxt = DUMMY;
            else                   state_nxt = RD_OUT;
          end
        end
        DUMMY: if (sck_rise && bit_cnt == CW'(DUMMY_CYC - 1)) state_nxt = RD_OUT;
        WR_IN: mem_we = sck_rise && (bit_cnt == CW'(7)) && wel;
        default: ;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      bit_cnt  <= '0;
      sh       <= '0;
      out_sh   <= '0;
      addr     <= '0;
      wel      <= 1'b0;
      last_cmd <= '0;
      io_o_r   <= '0;
      io_oe_r  <= '0;
    end else if (cs_rise) begin
      bit_cnt <= '0;
      io_o_r  <= '0;
      io_oe_r <= '0;
      // Write-enable latch only moves once a whole opcode has been received.
      if (state != IDLE && state != CMD) begin
        case (last_cmd)
          OP_WREN:        wel <= 1'b1;
          OP_WRDI, OP_PP: wel <= 1'b0;
          default: ;
        endcase
      end
    end else begin
      case (state)
        IDLE: bit_cnt <= '0;
        CMD: begin
          if (sck_rise) begin
            sh      <= opcode_in;
            bit_cnt <= (bit_cnt == CW'(7)) ? '0 : bit_cnt + CW'(1);
            if (bit_cnt == CW'(7)) last_cmd <= opcode_in;
          end
        end
        ADDR: begin
          if (sck_rise) begin
            addr    <= {addr[AW-2:0], io_s[0]};
            bit_cnt <= (bit_cnt == CW'(ADDR_SIZE - 1)) ? '0 : bit_cnt + CW'(1);
          end
        end
        DUMMY: begin
          if (sck_rise) bit_cnt <= (bit_cnt == CW'(DUMMY_CYC - 1)) ? '0 : bit_cnt + CW'(1);
        end
        WR_IN: begin
          if (sck_rise) begin
            sh <= mem_wd;
            if (bit_cnt == CW'(7)) begin
              bit_cnt <= '0;
              addr    <= addr + AW'(1);
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end
        end
        RD_OUT, STAT_OUT: begin
          // bit_cnt==0 marks the first fall; a full out_bits count reloads the next byte.
          if (sck_fall) begin
            if (bit_cnt == '0 || bit_cnt == out_bits) begin
              bit_cnt <= CW'(1);
              if (state == RD_OUT) addr <= addr + AW'(1);
              if (quad_mode) begin
                io_o_r  <= ld_byte[7:4];
                out_sh  <= {ld_byte[3:0], 4'b0};
                io_oe_r <= 4'b1111;
              end else begin
                io_o_r  <= {2'b00, ld_byte[7], 1'b0};
                out_sh  <= {ld_byte[6:0], 1'b0};
                io_oe_r <= 4'b0010;
              end
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
              if (quad_mode) begin
                io_o_r <= out_sh[7:4];
                out_sh <= {out_sh[3:0], 4'b0};
              end else begin
                io_o_r <= {2'b00, out_sh[7], 1'b0};
                out_sh <= {out_sh[6:0], 1'b0};
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Registered read of the current address keeps the next byte ready long before its first SCK fall.
  always_ff @(posedge ACLK) begin
    if (mem_we) mem[addr] <= mem_wd;
    mem_q <= mem[addr];
  end

endmodule

// File: tb/tb_qspi_flash_responder.sv
// Directed bench: drives the controller side of the link with SCK = ACLK/16 and checks read-back data.
`timescale 1ns/1ps
module tb_qspi_flash_responder;

  localparam int HALF = 8;

  logic       ACLK = 1'b0;
  logic       ARESET;
  logic       busy;
  logic [7:0] last_cmd;
  int         total = 0;
  int         passed = 0;
  logic [7:0] r0, r1;
  logic [3:0] o, oe;

  qspi_flash_responder_if spi();

  qspi_flash_responder #(.ADDR_SIZE(24), .MEM_BYTES(4096), .DUMMY_CYC(8)) dut (
    .ACLK     (ACLK),
    .ARESET   (ARESET),
    .spi      (spi.slave),
    .busy     (busy),
    .last_cmd (last_cmd)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge ACLK);
  endtask

  // One SCK period: present IO0, sample responder outputs just before the rise.
  task automatic sck_cycle(input logic d0, output logic [3:0] so, output logic [3:0] soe);
    spi.io_i = {3'b000, d0};
    wait_clk(HALF);
    so  = spi.io_o;
    soe = spi.io_oe;
    spi.spi_clk = 1'b1;
    wait_clk(HALF);
    spi.spi_clk = 1'b0;
  endtask

  task automatic xfer_byte(input logic [7:0] tx, output logic [7:0] rx, output logic [3:0] oe_last);
    logic [3:0] so;
    for (int i = 7; i >= 0; i--) begin
      sck_cycle(tx[i], so, oe_last);
      rx[i] = so[1];
    end
  endtask

  task automatic send_byte(input logic [7:0] tx);
    logic [7:0] rx;
    logic [3:0] soe;
    xfer_byte(tx, rx, soe);
  endtask

  task automatic send_addr(input logic [23:0] a);
    send_byte(a[23:16]);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
  endtask

  task automatic cs_begin();
    spi.spi_cs_n = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic cs_end();
    wait_clk(HALF);
    spi.spi_cs_n = 1'b1;
    wait_clk(2 * HALF);
  endtask

  task automatic do_simple(input logic [7:0] op);
    cs_begin();
    send_byte(op);
    cs_end();
  endtask

  task automatic do_pp(input logic [23:0] a, input logic [7:0] d0, input logic [7:0] d1, input int n);
    cs_begin();
    send_byte(8'h02);
    send_addr(a);
    if (n > 0) send_byte(d0);
    if (n > 1) send_byte(d1);
    cs_end();
  endtask

  task automatic do_read(input logic [23:0] a, output logic [7:0] b0, output logic [7:0] b1,
                         output logic [3:0] roe);
    cs_begin();
    send_byte(8'h03);
    send_addr(a);
    xfer_byte(8'h00, b0, roe);
    xfer_byte(8'h00, b1, roe);
    cs_end();
  endtask

  task automatic do_rdsr(output logic [7:0] s0, output logic [7:0] s1, output logic [3:0] roe);
    cs_begin();
    send_byte(8'h05);
    xfer_byte(8'h00, s0, roe);
    xfer_byte(8'h00, s1, roe);
    cs_end();
  endtask

  initial begin
    ARESET       = 1'b1;
    spi.spi_clk  = 1'b0;
    spi.spi_cs_n = 1'b1;
    spi.io_i     = 4'h0;
    wait_clk(5);
    ARESET = 1'b0;
    wait_clk(4);
    check("reset_io_o", 32'(spi.io_o), 32'h0);
    check("reset_io_oe", 32'(spi.io_oe), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_last_cmd", 32'(last_cmd), 32'h0);

    // Status after WREN: WEL in bit 1, repeated every byte.
    do_simple(8'h06);
    do_rdsr(r0, r1, oe);
    check("rdsr_wel_b0", 32'(r0), 32'h02);
    check("rdsr_wel_b1", 32'(r1), 32'h02);
    check("rdsr_oe", 32'(oe), 32'h2);

    do_pp(24'h000010, 8'hA5, 8'h3C, 2);
    do_rdsr(r0, r1, oe);
    check("rdsr_after_pp", 32'(r0), 32'h00);

    do_read(24'h000010, r0, r1, oe);
    check("read10_b0", 32'(r0), 32'hA5);
    check("read10_b1", 32'(r1), 32'h3C);
    check("read_last_cmd", 32'(last_cmd), 32'h03);
    check("read_oe", 32'(oe), 32'h2);

    // Address bits above bit 11 are discarded.
    do_read(24'h123010, r0, r1, oe);
    check("read_hi_addr", 32'(r0), 32'hA5);

    // PP with WEL clear must leave RAM untouched.
    do_simple(8'h06);
    do_pp(24'h000020, 8'h00, 8'h00, 1);
    do_pp(24'h000020, 8'hFF, 8'h00, 1);
    do_read(24'h000020, r0, r1, oe);
    check("pp_no_wel", 32'(r0), 32'h00);

    // Wrap at the top of the 4 KiB array, for both write and read.
    do_simple(8'h06);
    do_pp(24'h000FFF, 8'h11, 8'h22, 2);
    do_read(24'h000FFF, r0, r1, oe);
    check("wrap_b0", 32'(r0), 32'h11);
    check("wrap_b1", 32'(r1), 32'h22);

    // CS rise after 5 bits of the second data byte drops the partial byte.
    do_simple(8'h06);
    do_pp(24'h000030, 8'h00, 8'h00, 2);
    do_simple(8'h06);
    cs_begin();
    send_byte(8'h02);
    send_addr(24'h000030);
    send_byte(8'h77);
    for (int i = 0; i < 5; i++) sck_cycle(1'b1, o, oe);
    check("partial_busy_before", 32'(busy), 32'h1);
    spi.spi_cs_n = 1'b1;
    repeat (3) @(posedge ACLK);
    #1;
    check("partial_busy_after", 32'(busy), 32'h0);
    check("partial_oe_after", 32'(spi.io_oe), 32'h0);
    wait_clk(2 * HALF);
    do_read(24'h000030, r0, r1, oe);
    check("partial_b0", 32'(r0), 32'h77);
    check("partial_b1", 32'(r1), 32'h00);
    do_rdsr(r0, r1, oe);
    check("partial_wel_cleared", 32'(r0), 32'h00);

    // Quad read of 0x10 (A5,3C) or, without the feature, an ignored opcode.
    cs_begin();
    send_byte(8'h6B);
    send_addr(24'h000010);
    check("quad_last_cmd", 32'(last_cmd), 32'h6B);
    for (int i = 0; i < 8; i++) sck_cycle(1'b0, o, oe);
    check("quad_dummy_oe", 32'(oe), 32'h0);
`ifdef QSPI_QUAD_READ_EN
    sck_cycle(1'b0, o, oe);
    check("quad_n0", 32'(o), 32'hA);
    check("quad_oe", 32'(oe), 32'hF);
    sck_cycle(1'b0, o, oe);
    check("quad_n1", 32'(o), 32'h5);
    sck_cycle(1'b0, o, oe);
    check("quad_n2", 32'(o), 32'h3);
    sck_cycle(1'b0, o, oe);
    check("quad_n3", 32'(o), 32'hC);
`else
    for (int i = 0; i < 4; i++) sck_cycle(1'b0, o, oe);
    check("quad_off_oe", 32'(oe), 32'h0);
    check("quad_off_busy", 32'(busy), 32'h1);
`endif
    cs_end();

    // Reset mid-transaction: idle until the next CS fall, RAM preserved.
    cs_begin();
    send_byte(8'h03);
    send_byte(8'h00);
    ARESET = 1'b1;
    wait_clk(2);
    ARESET = 1'b0;
    wait_clk(1);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_last_cmd", 32'(last_cmd), 32'h0);
    send_byte(8'h00);
    send_byte(8'h10);
    xfer_byte(8'h00, r0, oe);
    check("midrst_oe", 32'(oe), 32'h0);
    check("midrst_busy_sck", 32'(busy), 32'h0);
    cs_end();
    do_read(24'h000010, r0, r1, oe);
    check("ram_kept_after_reset", 32'(r0), 32'hA5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
